// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register: opaque payload plus control vector,
// valid/ready flow control, optional 2-entry skid buffer, synchronous flush.
module pipe_stage_reg #(
  parameter int unsigned DATA_WIDTH          = 64,
  parameter int unsigned CTRL_WIDTH          = 16,
  parameter int unsigned SKID                = 1,
  parameter int unsigned CLEAR_DATA_ON_FLUSH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [1:0]            occupancy
);

  logic                  in_xfer;
  logic [DATA_WIDTH-1:0] main_data;
  logic [CTRL_WIDTH-1:0] main_ctrl;

  assign in_xfer  = in_valid & in_ready;
  assign out_data = main_data;
  // Bubbles must never carry live control bits downstream.
  assign out_ctrl = main_ctrl & {CTRL_WIDTH{out_valid}};

  if (SKID != 0) begin : g_skid
    typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [CTRL_WIDTH-1:0] skid_ctrl;

    // in_ready depends on state flops only, cutting the out_ready -> in_ready path.
    assign in_ready  = (state != S_TWO);
    assign out_valid = (state != S_EMPTY);
    assign occupancy = state;

    // NOTE: every flop here uses non-blocking assignment so all registers
    // update from the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= S_EMPTY;
        main_data <= '0;
        main_ctrl <= '0;
        skid_data <= '0;
        skid_ctrl <= '0;
      end else if (flush_in) begin
        state     <= S_EMPTY;
        main_ctrl <= '0;
        skid_ctrl <= '0;
        if (CLEAR_DATA_ON_FLUSH != 0) begin
          main_data <= '0;
          skid_data <= '0;
        end
      end else begin
        case (state)
          S_EMPTY: begin
            if (in_xfer) begin
              main_data <= in_data;
              main_ctrl <= in_ctrl;
              state     <= S_ONE;
            end
          end
          S_ONE: begin
            if (in_xfer && out_ready) begin
              main_data <= in_data;
              main_ctrl <= in_ctrl;
            end else if (in_xfer) begin
              skid_data <= in_data;
              skid_ctrl <= in_ctrl;
              state     <= S_TWO;
            end else if (out_ready) begin
              state <= S_EMPTY;
            end
          end
          S_TWO: begin
            if (out_ready) begin
              main_data <= skid_data;
              main_ctrl <= skid_ctrl;
              state     <= S_ONE;
            end
          end
          default: state <= S_EMPTY;
        endcase
      end
    end
  end else begin : g_single
    logic valid_q;

    assign out_valid = valid_q;
    assign in_ready  = out_ready | ~valid_q;
    assign occupancy = {1'b0, valid_q};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q   <= 1'b0;
        main_data <= '0;
        main_ctrl <= '0;
      end else if (flush_in) begin
        valid_q   <= 1'b0;
        main_ctrl <= '0;
        if (CLEAR_DATA_ON_FLUSH != 0) main_data <= '0;
      end else if (in_xfer) begin
        valid_q   <= 1'b1;
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: dut_a is SKID=1 with payload clear on
// flush, dut_b is SKID=0 with stale payload on flush.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  int          total = 0;
  int          bad   = 0;

  logic        a_flush, a_iv, a_ir, a_ov, a_or;
  logic [63:0] a_id, a_od;
  logic [15:0] a_ic, a_oc;
  logic [1:0]  a_occ;

  logic        b_flush, b_iv, b_ir, b_ov, b_or;
  logic [63:0] b_id, b_od;
  logic [15:0] b_ic, b_oc;
  logic [1:0]  b_occ;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_WIDTH(64), .CTRL_WIDTH(16), .SKID(1), .CLEAR_DATA_ON_FLUSH(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush_in(a_flush),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id), .in_ctrl(a_ic),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_ctrl(a_oc),
    .occupancy(a_occ)
  );

  pipe_stage_reg #(.DATA_WIDTH(64), .CTRL_WIDTH(16), .SKID(0), .CLEAR_DATA_ON_FLUSH(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush_in(b_flush),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id), .in_ctrl(b_ic),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_ctrl(b_oc),
    .occupancy(b_occ)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_flush = 0; a_iv = 1; a_id = 64'hAAAA; a_ic = 16'hFFFF; a_or = 0;
    b_flush = 0; b_iv = 1; b_id = 64'hAAAA; b_ic = 16'hFFFF; b_or = 0;
    step(); step();
    total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL reset_a_ov: got %b want 0", a_ov); end
    total++; if (a_oc !== 16'h0) begin bad++; $display("FAIL reset_a_oc: got %h want 0", a_oc); end
    total++; if (a_occ !== 2'd0) begin bad++; $display("FAIL reset_a_occ: got %0d want 0", a_occ); end
    total++; if (a_od !== 64'h0) begin bad++; $display("FAIL reset_a_od: got %h want 0", a_od); end
    total++; if (b_ov !== 1'b0) begin bad++; $display("FAIL reset_b_ov: got %b want 0", b_ov); end
    total++; if (b_occ !== 2'd0) begin bad++; $display("FAIL reset_b_occ: got %0d want 0", b_occ); end
    a_iv = 0; b_iv = 0;
    rst_n = 1'b1;
    #1;
    total++; if (a_ir !== 1'b1) begin bad++; $display("FAIL reset_a_ir: got %b want 1", a_ir); end
    total++; if (b_ir !== 1'b1) begin bad++; $display("FAIL reset_b_ir: got %b want 1", b_ir); end
  endtask

  task automatic test_stream_a();
    a_or = 1;
    for (int i = 1; i <= 8; i++) begin
      a_iv = 1; a_id = 64'(i); a_ic = 16'(i);
      step();
      total++; if (a_ov !== 1'b1 || a_od !== 64'(i) || a_oc !== 16'(i))
        begin bad++; $display("FAIL stream_a_%0d: got v=%b d=%h c=%h want v=1 d=%h c=%h", i, a_ov, a_od, a_oc, i, i); end
      total++; if (a_occ !== 2'd1 || a_ir !== 1'b1)
        begin bad++; $display("FAIL stream_a_occ_%0d: got occ=%0d ir=%b want occ=1 ir=1", i, a_occ, a_ir); end
    end
    a_iv = 0;
    step();
    total++; if (a_ov !== 1'b0 || a_oc !== 16'h0 || a_occ !== 2'd0)
      begin bad++; $display("FAIL stream_a_drain: got v=%b c=%h occ=%0d want v=0 c=0 occ=0", a_ov, a_oc, a_occ); end
  endtask

  task automatic test_skid_a();
    a_or = 0;
    a_iv = 1; a_id = 64'h11; a_ic = 16'h0011;
    step();
    total++; if (a_occ !== 2'd1 || a_ir !== 1'b1 || a_od !== 64'h11)
      begin bad++; $display("FAIL skid_first: got occ=%0d ir=%b d=%h want occ=1 ir=1 d=11", a_occ, a_ir, a_od); end
    a_id = 64'h22; a_ic = 16'h0022;
    step();
    total++; if (a_occ !== 2'd2 || a_ir !== 1'b0)
      begin bad++; $display("FAIL skid_full: got occ=%0d ir=%b want occ=2 ir=0", a_occ, a_ir); end
    total++; if (a_od !== 64'h11 || a_oc !== 16'h0011)
      begin bad++; $display("FAIL skid_head: got d=%h c=%h want d=11 c=0011", a_od, a_oc); end
    a_iv = 0;
    step();
    total++; if (a_od !== 64'h11 || a_occ !== 2'd2)
      begin bad++; $display("FAIL skid_hold: got d=%h occ=%0d want d=11 occ=2", a_od, a_occ); end
    a_or = 1;
    step();
    total++; if (a_od !== 64'h22 || a_oc !== 16'h0022 || a_occ !== 2'd1 || a_ir !== 1'b1)
      begin bad++; $display("FAIL skid_drain: got d=%h c=%h occ=%0d ir=%b want d=22 c=0022 occ=1 ir=1", a_od, a_oc, a_occ, a_ir); end
    step();
    total++; if (a_ov !== 1'b0 || a_occ !== 2'd0)
      begin bad++; $display("FAIL skid_empty: got v=%b occ=%0d want v=0 occ=0", a_ov, a_occ); end
  endtask

  task automatic test_flush_a();
    a_or = 0; a_iv = 1; a_ic = 16'hFFFF;
    a_id = 64'h01; step();
    a_id = 64'h02; step();
    total++; if (a_occ !== 2'd2) begin bad++; $display("FAIL flush_a_fill: got occ=%0d want 2", a_occ); end
    a_flush = 1; a_id = 64'h33; a_or = 1;
    step();
    a_flush = 0; a_iv = 0;
    total++; if (a_ov !== 1'b0 || a_oc !== 16'h0 || a_occ !== 2'd0)
      begin bad++; $display("FAIL flush_a_state: got v=%b c=%h occ=%0d want v=0 c=0 occ=0", a_ov, a_oc, a_occ); end
    total++; if (a_od !== 64'h0) begin bad++; $display("FAIL flush_a_data: got %h want 0", a_od); end
    step();
    total++; if (a_ov !== 1'b0 || a_ir !== 1'b1)
      begin bad++; $display("FAIL flush_a_after: got v=%b ir=%b want v=0 ir=1", a_ov, a_ir); end
  endtask

  task automatic test_reset_midstream_a();
    a_or = 0; a_iv = 1; a_ic = 16'h00F0;
    a_id = 64'h07; step();
    a_id = 64'h08; step();
    a_iv = 0;
    rst_n = 1'b0;
    #1;
    total++; if (a_ov !== 1'b0 || a_occ !== 2'd0 || a_od !== 64'h0 || a_ir !== 1'b1)
      begin bad++; $display("FAIL midreset_a: got v=%b occ=%0d d=%h ir=%b want v=0 occ=0 d=0 ir=1", a_ov, a_occ, a_od, a_ir); end
    step();
    rst_n = 1'b1;
    a_or = 1; a_iv = 1; a_id = 64'h09; a_ic = 16'h0009;
    step();
    a_iv = 0;
    total++; if (a_ov !== 1'b1 || a_od !== 64'h09)
      begin bad++; $display("FAIL midreset_a_resume: got v=%b d=%h want v=1 d=09", a_ov, a_od); end
    step();
  endtask

  task automatic test_stream_b();
    b_or = 1;
    for (int i = 1; i <= 8; i++) begin
      b_iv = 1; b_id = 64'(i + 100); b_ic = 16'(i);
      step();
      total++; if (b_ov !== 1'b1 || b_od !== 64'(i + 100) || b_occ !== 2'd1)
        begin bad++; $display("FAIL stream_b_%0d: got v=%b d=%h occ=%0d want v=1 d=%h occ=1", i, b_ov, b_od, b_occ, i + 100); end
    end
    b_iv = 0;
    step();
    total++; if (b_ov !== 1'b0 || b_oc !== 16'h0 || b_occ !== 2'd0)
      begin bad++; $display("FAIL stream_b_drain: got v=%b c=%h occ=%0d want v=0 c=0 occ=0", b_ov, b_oc, b_occ); end
  endtask

  task automatic test_stall_b();
    b_or = 0; b_iv = 1; b_id = 64'h44; b_ic = 16'h0004;
    step();
    total++; if (b_ov !== 1'b1 || b_od !== 64'h44)
      begin bad++; $display("FAIL stall_b_load: got v=%b d=%h want v=1 d=44", b_ov, b_od); end
    b_id = 64'h55; b_ic = 16'h0005;
    #1;
    total++; if (b_ir !== 1'b0) begin bad++; $display("FAIL stall_b_ir_low: got %b want 0", b_ir); end
    step();
    total++; if (b_od !== 64'h44 || b_oc !== 16'h0004 || b_occ !== 2'd1)
      begin bad++; $display("FAIL stall_b_hold: got d=%h c=%h occ=%0d want d=44 c=0004 occ=1", b_od, b_oc, b_occ); end
    b_or = 1;
    #1;
    total++; if (b_ir !== 1'b1) begin bad++; $display("FAIL stall_b_ir_comb: got %b want 1", b_ir); end
    step();
    b_iv = 0;
    total++; if (b_ov !== 1'b1 || b_od !== 64'h55)
      begin bad++; $display("FAIL stall_b_next: got v=%b d=%h want v=1 d=55", b_ov, b_od); end
    step();
    total++; if (b_ov !== 1'b0) begin bad++; $display("FAIL stall_b_empty: got %b want 0", b_ov); end
  endtask

  task automatic test_flush_b();
    b_or = 0; b_iv = 1; b_id = 64'h66; b_ic = 16'hFFFF;
    step();
    b_flush = 1; b_id = 64'h33;
    step();
    b_flush = 0; b_iv = 0;
    total++; if (b_ov !== 1'b0 || b_oc !== 16'h0 || b_occ !== 2'd0 || b_ir !== 1'b1)
      begin bad++; $display("FAIL flush_b_state: got v=%b c=%h occ=%0d ir=%b want v=0 c=0 occ=0 ir=1", b_ov, b_oc, b_occ, b_ir); end
    total++; if (b_od !== 64'h66) begin bad++; $display("FAIL flush_b_stale: got %h want 66", b_od); end
    step();
    total++; if (b_ov !== 1'b0) begin bad++; $display("FAIL flush_b_after: got %b want 0", b_ov); end
  endtask

  initial begin
    test_reset();
    test_stream_a();
    test_skid_a();
    test_flush_a();
    test_reset_midstream_a();
    test_stream_b();
    test_stall_b();
    test_flush_b();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
